move_validator_seq: RTL and testbench
=====================================

Name: move_validator_seq

Overview:
Sequential, parametrised successor to the combinational move checker. It accepts one move request over a valid/ready handshake and reads the board one square per cycle through a synchronous read port, instead of taking a full 8x8 array input. It returns a registered verdict and a reason code. New behaviour over the previous generation:
- colour-aware pawn direction
- own-piece capture rejection
- null-move rejection
- early abort on the first blocker

It sits between the game-play controller and the board RAM.

Parameters:
N, 8, board dimension (squares per side, N >= 4)
CW, $clog2(N), coordinate width
PW, 4, piece code width
EMPTY, 15, piece code of an empty square

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  move request present
req_ready  out  1  block can accept a request (high only in IDLE)
old_x, old_y  in  CW  source square
new_x, new_y  in  CW  destination square
piece_type  in  PW  moving piece: 0-5 side A (rook, knight, bishop, queen, king, pawn), 6-11 side B (same order)
rd_en  out  1  board read strobe
rd_x, rd_y  out  CW  board read address
rd_data  in  PW  board contents; valid the cycle after rd_en
out_valid  out  1  verdict present; held until accepted
out_ready  in  1  consumer accepts verdict
valid_move  out  1  1 = legal move
reason  out  3  0 OK, 1 BAD_SHAPE, 2 BLOCKED, 3 OWN_CAPTURE, 4 PAWN_RULE

Behaviour:
- Reset, synchronous: state=IDLE; req_ready=1; out_valid=0; valid_move=0; reason=0; rd_en=0; rd_x=rd_y=0. Any in-flight request is discarded.
- Request capture: at cycle T (req_valid && req_ready), coordinates and piece are registered.
- FSM: IDLE -> CLASS -> DEST -> WALK -> RESULT -> IDLE.
- CLASS (T+1):
  - Compute dx, dy as absolute differences (CW bits) and the step direction per axis (-1/0/+1).
  - K = number of intermediate squares: max(dx,dy)-1 for sliders, 0 for knight and king, 1 for a pawn double step, else 0.
  - BAD_SHAPE if any of: dx=dy=0; piece code > 11; rook not orthogonal; bishop not diagonal; queen neither; knight not (2,1)/(1,2); king delta > 1.
  - Pawn rules: side A moves toward y decreasing and starts on row N-2; side B moves toward y increasing and starts on row 1. Allowed shapes are forward 1 straight, forward 2 straight from the start row, or forward 1 diagonal. Anything else (including the wrong direction) gives PAWN_RULE.
  - Any failure in CLASS goes straight to RESULT, so out_valid rises at T+2.
- DEST (T+2): rd_en=1, read address = destination.
- WALK, from T+3:
  - Check the destination data at T+3:
    - dest owned by the mover's own side (same code range) -> OWN_CAPTURE
    - pawn straight move onto a non-EMPTY square -> PAWN_RULE
    - pawn diagonal onto EMPTY -> PAWN_RULE
  - In the same cycles T+3 .. T+2+K, issue intermediate reads along the step vector, one per cycle, pipelined. Data for intermediate square i is checked at T+3+i.
  - First non-EMPTY intermediate -> BLOCKED. Verdict at T+4+i; remaining reads are suppressed (rd_en=0 after the abort).
  - A destination failure takes priority over BLOCKED.
- Latency: a clear path gives out_valid at T+4+K. Knight and king always take T+4.
- RESULT:
  - out_valid=1; valid_move=(reason==0).
  - valid_move and reason remain stable while out_valid && !out_ready.
  - On out_valid && out_ready: return to IDLE and drop out_valid the next cycle. req_ready rises the same next cycle; there is no back-to-back overlap.
- req_valid outside IDLE is ignored; the upstream block must hold the request.
- Arithmetic: intermediate coordinates never wrap, because the shape check guarantees every square stays on the board. Step counters are CW bits wide.
- Reset asserted mid-WALK or mid-RESULT aborts the operation; no verdict is produced.

Decomposition:
- Package chess_pkg holds:
  - piece code enum (ROOK..PAWN, side offset 6, EMPTY)
  - reason_t enum
  - side_of() and kind_of() functions
  - pawn start-row constants derived from N
- Sub-module move_shape_classifier: purely combinational. Inputs are the coords and piece; outputs are K, step_x, step_y, is_pawn_diag, shape_fail and fail reason. It is used in CLASS; the FSM, read pipeline and handshake stay in the top module.

Test Plan:
- Rook A (0,7)->(0,3), column empty, dest EMPTY, req at T -> rd addresses (0,3),(0,6),(0,5),(0,4) at T+2..T+5; out_valid at T+7, valid_move=1, reason=0.
- Same move with (0,5)=pawn -> BLOCKED (reason 2) at T+6; no read of (0,4).
- Knight A (1,7)->(2,5) with dest holding side-A pawn (code 5) -> OWN_CAPTURE (reason 3) at T+4; with dest code 11 -> valid at T+4.
- Pawn B (4,1)->(4,3), squares (4,2),(4,3) EMPTY -> valid; pawn B (4,3)->(4,2) -> PAWN_RULE at T+2; pawn A diagonal onto EMPTY -> PAWN_RULE at T+4.
- Null move (3,3)->(3,3) queen, and bishop (2,7)->(2,4) -> BAD_SHAPE at T+2 with no rd_en pulse.
- out_ready held low 5 cycles -> verdict stable and req_ready=0 throughout; reset pulsed during WALK -> out_valid never asserts and req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess definitions for the sequential move validator.
// Contents: piece code enum, verdict reason enum, side/kind helpers and
// pawn start-row constants.
package chess_pkg;

  // Side-A codes. Side B uses the same kinds offset by SIDE_OFFSET.
  typedef enum logic [3:0] {
    P_ROOK   = 4'd0,
    P_KNIGHT = 4'd1,
    P_BISHOP = 4'd2,
    P_QUEEN  = 4'd3,
    P_KING   = 4'd4,
    P_PAWN   = 4'd5,
    P_EMPTY  = 4'd15
  } piece_e;

  typedef enum logic [2:0] {
    R_OK          = 3'd0,
    R_BAD_SHAPE   = 3'd1,
    R_BLOCKED     = 3'd2,
    R_OWN_CAPTURE = 3'd3,
    R_PAWN_RULE   = 3'd4
  } reason_t;

  localparam int unsigned SIDE_OFFSET  = 6;
  localparam int unsigned MAX_PIECE    = 11;
  localparam int unsigned PAWN_START_B = 1;

  // 0 = side A, 1 = side B (meaningful only for codes <= MAX_PIECE)
  function automatic logic side_of(input int unsigned code);
    return code >= SIDE_OFFSET;
  endfunction

  function automatic int unsigned kind_of(input int unsigned code);
    return (code >= SIDE_OFFSET) ? code - SIDE_OFFSET : code;
  endfunction

  // Side A starts one row short of the far edge and moves toward row 0.
  function automatic int unsigned pawn_start_a(input int unsigned n);
    return n - 2;
  endfunction

endpackage

// File: rtl/move_shape_classifier.sv
// Combinational move shape check.
// Inputs : old_x/old_y, new_x/new_y (coords), piece (piece code)
// Outputs: k (intermediate square count), step_x/step_y (2'b01 = +1,
//          2'b11 = -1, 2'b00 = 0), is_pawn_diag, shape_fail, fail_reason
module move_shape_classifier
  import chess_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N),
  parameter int unsigned PW = 4
) (
  input  logic [CW-1:0] old_x,
  input  logic [CW-1:0] old_y,
  input  logic [CW-1:0] new_x,
  input  logic [CW-1:0] new_y,
  input  logic [PW-1:0] piece,
  output logic [CW-1:0] k,
  output logic [1:0]    step_x,
  output logic [1:0]    step_y,
  output logic          is_pawn_diag,
  output logic          shape_fail,
  output reason_t       fail_reason
);

  logic [CW-1:0] dx, dy, dmax;
  logic [3:0]    kind;
  logic          side_b, orth, diag, fwd, at_start;

  always_comb begin
    dx       = (new_x >= old_x) ? new_x - old_x : old_x - new_x;
    dy       = (new_y >= old_y) ? new_y - old_y : old_y - new_y;
    dmax     = (dx > dy) ? dx : dy;
    step_x   = (new_x > old_x) ? 2'b01 : ((new_x < old_x) ? 2'b11 : 2'b00);
    step_y   = (new_y > old_y) ? 2'b01 : ((new_y < old_y) ? 2'b11 : 2'b00);
    // kind is only consulted once the code is known to be <= MAX_PIECE
    kind     = 4'(kind_of(32'(piece)));
    side_b   = side_of(32'(piece));
    orth     = (dx == '0) || (dy == '0);
    diag     = (dx == dy);
    fwd      = side_b ? (new_y > old_y) : (new_y < old_y);
    at_start = side_b ? (old_y == CW'(PAWN_START_B)) : (old_y == CW'(pawn_start_a(N)));

    k            = '0;
    is_pawn_diag = 1'b0;
    shape_fail   = 1'b0;
    fail_reason  = R_OK;

    if (((dx == '0) && (dy == '0)) || (32'(piece) > MAX_PIECE)) begin
      shape_fail  = 1'b1;
      fail_reason = R_BAD_SHAPE;
    end else begin
      case (kind)
        P_ROOK: begin
          if (!orth) begin shape_fail = 1'b1; fail_reason = R_BAD_SHAPE; end
          else k = dmax - CW'(1);
        end
        P_BISHOP: begin
          if (!diag) begin shape_fail = 1'b1; fail_reason = R_BAD_SHAPE; end
          else k = dmax - CW'(1);
        end
        P_QUEEN: begin
          if (!orth && !diag) begin shape_fail = 1'b1; fail_reason = R_BAD_SHAPE; end
          else k = dmax - CW'(1);
        end
        P_KNIGHT: begin
          if (!(((dx == CW'(2)) && (dy == CW'(1))) || ((dx == CW'(1)) && (dy == CW'(2))))) begin
            shape_fail = 1'b1; fail_reason = R_BAD_SHAPE;
          end
        end
        P_KING: begin
          if (dmax > CW'(1)) begin shape_fail = 1'b1; fail_reason = R_BAD_SHAPE; end
        end
        P_PAWN: begin
          if (fwd && (dx == '0) && (dy == CW'(1))) begin
            k = '0;
          end else if (fwd && (dx == '0) && (dy == CW'(2)) && at_start) begin
            k = CW'(1);
          end else if (fwd && (dx == CW'(1)) && (dy == CW'(1))) begin
            is_pawn_diag = 1'b1;
          end else begin
            shape_fail = 1'b1; fail_reason = R_PAWN_RULE;
          end
        end
        default: begin
          shape_fail = 1'b1; fail_reason = R_BAD_SHAPE;
        end
      endcase
    end
  end

endmodule

// File: rtl/move_validator_seq.sv
// Sequential chess move validator reading the board one square per cycle.
// Ports: clk/reset (sync, active-high); req_valid/req_ready + old/new coords
// and piece_type (request); rd_en/rd_x/rd_y/rd_data (board read port, data
// one cycle after rd_en); out_valid/out_ready + valid_move/reason (verdict).
module move_validator_seq
  import chess_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CW    = $clog2(N),
  parameter int unsigned PW    = 4,
  parameter int unsigned EMPTY = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] old_x,
  input  logic [CW-1:0] old_y,
  input  logic [CW-1:0] new_x,
  input  logic [CW-1:0] new_y,
  input  logic [PW-1:0] piece_type,
  output logic          rd_en,
  output logic [CW-1:0] rd_x,
  output logic [CW-1:0] rd_y,
  input  logic [PW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          valid_move,
  output logic [2:0]    reason
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLASS  = 3'd1;
  localparam logic [2:0] S_DEST   = 3'd2;
  localparam logic [2:0] S_WALK   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] ox_q, ox_d, oy_q, oy_d, nx_q, nx_d, ny_q, ny_d;
  logic [PW-1:0] piece_q, piece_d;
  logic [CW-1:0] k_q, k_d, iss_q, iss_d, chk_q, chk_d;
  logic [CW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [1:0]    sx_q, sx_d, sy_q, sy_d;
  logic          pdiag_q, pdiag_d;
  reason_t       reason_q, reason_d;
  logic          req_ready_q, req_ready_d, out_valid_q, out_valid_d;
  logic          valid_move_q, valid_move_d, rd_en_q, rd_en_d;
  logic [CW-1:0] rd_x_q, rd_x_d, rd_y_q, rd_y_d;

  logic [CW-1:0] cls_k;
  logic [1:0]    cls_sx, cls_sy;
  logic          cls_pdiag, cls_fail, issue;
  reason_t       cls_reason;
  logic          walk_fail_c;
  reason_t       walk_reason_c;
  logic          is_pawn, dest_empty, dest_own;

  function automatic logic [CW-1:0] step_add(input logic [CW-1:0] c, input logic [1:0] s);
    case (s)
      2'b01:   step_add = c + CW'(1);
      2'b11:   step_add = c - CW'(1);
      default: step_add = c;
    endcase
  endfunction

  move_shape_classifier #(.N(N), .CW(CW), .PW(PW)) u_class (
    .old_x       (ox_q),
    .old_y       (oy_q),
    .new_x       (nx_q),
    .new_y       (ny_q),
    .piece       (piece_q),
    .k           (cls_k),
    .step_x      (cls_sx),
    .step_y      (cls_sy),
    .is_pawn_diag(cls_pdiag),
    .shape_fail  (cls_fail),
    .fail_reason (cls_reason)
  );

  // Read-data check in WALK: first cycle sees the destination, later cycles
  // see intermediates in path order.
  always_comb begin
    is_pawn       = (kind_of(32'(piece_q)) == 32'(P_PAWN));
    dest_empty    = (rd_data == PW'(EMPTY));
    dest_own      = !dest_empty && (32'(rd_data) <= MAX_PIECE) &&
                    (side_of(32'(rd_data)) == side_of(32'(piece_q)));
    walk_fail_c   = 1'b0;
    walk_reason_c = R_OK;
    if (state_q == S_WALK) begin
      if (chk_q == '0) begin
        if (dest_own) begin
          walk_fail_c = 1'b1; walk_reason_c = R_OWN_CAPTURE;
        end else if (is_pawn && (pdiag_q == dest_empty)) begin
          walk_fail_c = 1'b1; walk_reason_c = R_PAWN_RULE;
        end
      end else if (!dest_empty) begin
        walk_fail_c = 1'b1; walk_reason_c = R_BLOCKED;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    nx_d         = nx_q;
    ny_d         = ny_q;
    piece_d      = piece_q;
    k_d          = k_q;
    iss_d        = iss_q;
    chk_d        = chk_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    pdiag_d      = pdiag_q;
    reason_d     = reason_q;
    req_ready_d  = req_ready_q;
    out_valid_d  = out_valid_q;
    valid_move_d = valid_move_q;
    rd_en_d      = 1'b0;
    rd_x_d       = rd_x_q;
    rd_y_d       = rd_y_q;
    issue        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          ox_d        = old_x;
          oy_d        = old_y;
          nx_d        = new_x;
          ny_d        = new_y;
          piece_d     = piece_type;
          reason_d    = R_OK;
          req_ready_d = 1'b0;
          state_d     = S_CLASS;
        end
      end
      S_CLASS: begin
        k_d     = cls_k;
        sx_d    = cls_sx;
        sy_d    = cls_sy;
        pdiag_d = cls_pdiag;
        if (cls_fail) begin
          reason_d     = cls_reason;
          out_valid_d  = 1'b1;
          valid_move_d = 1'b0;
          state_d      = S_RESULT;
        end else begin
          rd_en_d = 1'b1;
          rd_x_d  = nx_q;
          rd_y_d  = ny_q;
          cur_x_d = step_add(ox_q, cls_sx);
          cur_y_d = step_add(oy_q, cls_sy);
          iss_d   = '0;
          chk_d   = '0;
          state_d = S_DEST;
        end
      end
      S_DEST: begin
        state_d = S_WALK;
        issue   = (iss_q < k_q);
      end
      S_WALK: begin
        chk_d = chk_q + CW'(1);
        if (walk_fail_c) begin
          reason_d     = walk_reason_c;
          out_valid_d  = 1'b1;
          valid_move_d = 1'b0;
          state_d      = S_RESULT;
        end else if (chk_q == k_q) begin
          out_valid_d  = 1'b1;
          valid_move_d = 1'b1;
          state_d      = S_RESULT;
        end else begin
          issue = (iss_q < k_q);
        end
      end
      S_RESULT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase

    // Pipelined intermediate read along the step vector.
    if (issue) begin
      rd_en_d = 1'b1;
      rd_x_d  = cur_x_q;
      rd_y_d  = cur_y_q;
      cur_x_d = step_add(cur_x_q, sx_q);
      cur_y_d = step_add(cur_y_q, sy_q);
      iss_d   = iss_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ox_q         <= '0;
      oy_q         <= '0;
      nx_q         <= '0;
      ny_q         <= '0;
      piece_q      <= '0;
      k_q          <= '0;
      iss_q        <= '0;
      chk_q        <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      pdiag_q      <= 1'b0;
      reason_q     <= R_OK;
      req_ready_q  <= 1'b1;
      out_valid_q  <= 1'b0;
      valid_move_q <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
    end else begin
      state_q      <= state_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      nx_q         <= nx_d;
      ny_q         <= ny_d;
      piece_q      <= piece_d;
      k_q          <= k_d;
      iss_q        <= iss_d;
      chk_q        <= chk_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      pdiag_q      <= pdiag_d;
      reason_q     <= reason_d;
      req_ready_q  <= req_ready_d;
      out_valid_q  <= out_valid_d;
      valid_move_q <= valid_move_d;
      rd_en_q      <= rd_en_d;
      rd_x_q       <= rd_x_d;
      rd_y_q       <= rd_y_d;
    end
  end

  // A read already scheduled for the abort cycle is withdrawn so no square
  // past the first blocker (or after a failed destination) is fetched.
  assign rd_en      = rd_en_q && !walk_fail_c;
  assign rd_x       = rd_x_q;
  assign rd_y       = rd_y_q;
  assign req_ready  = req_ready_q;
  assign out_valid  = out_valid_q;
  assign valid_move = valid_move_q;
  assign reason     = reason_q;

endmodule

// File: tb/tb_move_validator_seq.sv
// Self-checking bench for move_validator_seq: directed cases with literal
// expectations plus randomized boards and moves against a rule-level model.
module tb_move_validator_seq;

  localparam int N     = 8;
  localparam int CW    = 3;
  localparam int PW    = 4;
  localparam int EMPTY = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [CW-1:0] old_x, old_y, new_x, new_y;
  logic [PW-1:0] piece_type;
  logic          rd_en;
  logic [CW-1:0] rd_x, rd_y;
  logic [PW-1:0] rd_data = 4'(EMPTY);
  logic          out_valid, out_ready, valid_move;
  logic [2:0]    reason;

  move_validator_seq #(.N(N), .CW(CW), .PW(PW), .EMPTY(EMPTY)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .old_x     (old_x),
    .old_y     (old_y),
    .new_x     (new_x),
    .new_y     (new_y),
    .piece_type(piece_type),
    .rd_en     (rd_en),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .valid_move(valid_move),
    .reason    (reason)
  );

  always #5 clk = ~clk;

  // Board RAM: board[x][y], synchronous read.
  logic [3:0] board [N][N];
  always @(posedge clk) if (rd_en) rd_data <= board[rd_x][rd_y];

  int n_cmp = 0;
  int n_err = 0;
  int txn_id = 0;
  int cyc = 0;

  bit exp_rd_en [64];
  int exp_rd_x  [64];
  int exp_rd_y  [64];
  int exp_reason, exp_lat;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (txn %0d cycle %0d)", name, act, exp, txn_id, cyc);
    end
  endtask

  task automatic clear_board();
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++)
        board[x][y] = 4'(EMPTY);
  endtask

  // Rule-level model: expected reason, verdict cycle (relative to request
  // cycle T) and the read schedule.
  task automatic model(input int pc, input int ox, input int oy, input int nx, input int ny);
    int dx, dy, sx, sy, mx, kind, side, k, fwd, start, dv;
    bit pawn, pdiag;
    for (int c = 0; c < 64; c++) begin
      exp_rd_en[c] = 1'b0; exp_rd_x[c] = 0; exp_rd_y[c] = 0;
    end
    dx = (nx > ox) ? nx - ox : ox - nx;
    dy = (ny > oy) ? ny - oy : oy - ny;
    sx = (nx > ox) ? 1 : ((nx < ox) ? -1 : 0);
    sy = (ny > oy) ? 1 : ((ny < oy) ? -1 : 0);
    mx = (dx > dy) ? dx : dy;
    kind = pc % 6;
    side = pc / 6;
    k = 0; pawn = 1'b0; pdiag = 1'b0; exp_reason = 0;
    if ((dx == 0 && dy == 0) || pc > 11) exp_reason = 1;
    else begin
      case (kind)
        0: if (dx != 0 && dy != 0) exp_reason = 1; else k = mx - 1;
        1: if (dx * dy != 2) exp_reason = 1;
        2: if (dx != dy) exp_reason = 1; else k = mx - 1;
        3: if (dx != 0 && dy != 0 && dx != dy) exp_reason = 1; else k = mx - 1;
        4: if (mx > 1) exp_reason = 1;
        default: begin
          pawn  = 1'b1;
          fwd   = (side == 0) ? -1 : 1;
          start = (side == 0) ? N - 2 : 1;
          if (nx == ox && ny == oy + fwd) k = 0;
          else if (nx == ox && ny == oy + 2 * fwd && oy == start) k = 1;
          else if (dx == 1 && ny == oy + fwd) pdiag = 1'b1;
          else exp_reason = 4;
        end
      endcase
    end
    if (exp_reason != 0) begin exp_lat = 2; return; end
    exp_rd_en[2] = 1'b1; exp_rd_x[2] = nx; exp_rd_y[2] = ny;
    dv = int'(board[nx][ny]);
    if (dv != EMPTY && dv < 12 && dv / 6 == side) exp_reason = 3;
    else if (pawn && !pdiag && dv != EMPTY) exp_reason = 4;
    else if (pawn && pdiag && dv == EMPTY) exp_reason = 4;
    if (exp_reason != 0) begin exp_lat = 4; return; end
    exp_lat = 4 + k;
    for (int i = 1; i <= k; i++) begin
      exp_rd_en[2 + i] = 1'b1;
      exp_rd_x[2 + i]  = ox + i * sx;
      exp_rd_y[2 + i]  = oy + i * sy;
      if (int'(board[ox + i * sx][oy + i * sy]) != EMPTY) begin
        exp_reason = 2; exp_lat = 4 + i; break;
      end
    end
  endtask

  // One request; called at a negedge with the DUT idle. Literal expectations
  // of -1 are skipped.
  task automatic run_txn(input int pc, input int ox, input int oy, input int nx, input int ny,
                         input int hold, input int lit_reason, input int lit_lat);
    int seen_lat, seen_reason;
    bit done;
    txn_id++;
    model(pc, ox, oy, nx, ny);
    chk("idle_req_ready", int'(req_ready), 1);
    req_valid = 1'b1; out_ready = 1'b0;
    old_x = CW'(ox); old_y = CW'(oy); new_x = CW'(nx); new_y = CW'(ny);
    piece_type = PW'(pc);
    @(posedge clk); @(negedge clk);
    seen_lat = -1; seen_reason = -1; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      cyc = c;
      // request lines are junk while busy and must be ignored
      req_valid = 1'($urandom); old_x = CW'($urandom); new_y = CW'($urandom);
      piece_type = PW'($urandom);
      chk("busy_req_ready", int'(req_ready), 0);
      chk("rd_en", int'(rd_en), int'(exp_rd_en[c]));
      if (exp_rd_en[c] && rd_en) begin
        chk("rd_x", int'(rd_x), exp_rd_x[c]);
        chk("rd_y", int'(rd_y), exp_rd_y[c]);
      end
      chk("out_valid", int'(out_valid), int'(c >= exp_lat));
      if (out_valid && seen_lat < 0) begin seen_lat = c; seen_reason = int'(reason); end
      if (c >= exp_lat) begin
        chk("valid_move", int'(valid_move), int'(exp_reason == 0));
        chk("reason", int'(reason), exp_reason);
      end
      if (c == exp_lat + hold) begin
        out_ready = 1'b1; req_valid = 1'b0; done = 1'b1;
      end else if (!done) begin
        @(negedge clk);
      end
    end
    if (!done) begin chk("verdict_timeout", 0, 1); req_valid = 1'b0; end
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_out_valid", int'(out_valid), 0);
    chk("post_req_ready", int'(req_ready), 1);
    if (lit_lat >= 0)    chk("lit_latency", seen_lat, lit_lat);
    if (lit_reason >= 0) chk("lit_reason", seen_reason, lit_reason);
  endtask

  initial begin
    int pc, ox, oy, nx, ny, mode, d, sx, sy, tx, ty;
    reset = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
    old_x = '0; old_y = '0; new_x = '0; new_y = '0; piece_type = '0;
    clear_board();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_valid_move", int'(valid_move), 0);
    chk("rst_reason", int'(reason), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_xy", int'({rd_x, rd_y}), 0);
    reset = 1'b0;
    @(negedge clk);

    // Rook A down an empty column, then blocked at (0,5).
    run_txn(0, 0, 7, 0, 3, 0, 0, 7);
    board[0][5] = 4'd5;
    run_txn(0, 0, 7, 0, 3, 0, 2, 6);
    // Knight A onto own pawn, then onto side-B pawn.
    clear_board();
    board[2][5] = 4'd5;
    run_txn(1, 1, 7, 2, 5, 0, 3, 4);
    board[2][5] = 4'd11;
    run_txn(1, 1, 7, 2, 5, 0, 0, 4);
    // Pawn rules.
    clear_board();
    run_txn(11, 4, 1, 4, 3, 0, 0, 5);
    run_txn(11, 4, 3, 4, 2, 0, 4, 2);
    run_txn(5, 4, 6, 5, 5, 0, 4, 4);
    board[4][2] = 4'd0;
    run_txn(11, 4, 1, 4, 3, 0, 2, 5);
    clear_board();
    // Null move and off-diagonal bishop.
    run_txn(3, 3, 3, 3, 3, 0, 1, 2);
    run_txn(2, 2, 7, 2, 4, 0, 1, 2);
    // Consumer stall: verdict must stay put for 5 cycles.
    run_txn(3, 0, 0, 7, 7, 5, 0, 10);

    // Reset pulsed during WALK aborts the operation.
    txn_id++;
    req_valid = 1'b1; old_x = 3'd0; old_y = 3'd7; new_x = 3'd0; new_y = 3'd0;
    piece_type = 4'd0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc = i;
      @(negedge clk);
      chk("rst_walk_out_valid", int'(out_valid), 0);
      chk("rst_walk_req_ready", int'(req_ready), 1);
    end

    // Randomized boards and moves.
    for (int t = 0; t < 300; t++) begin
      if (t % 10 == 0)
        for (int x = 0; x < N; x++)
          for (int y = 0; y < N; y++)
            board[x][y] = ($urandom % 4 == 0) ? 4'($urandom % 15) : 4'(EMPTY);
      pc = int'($urandom % 14);
      ox = int'($urandom % N); oy = int'($urandom % N);
      nx = int'($urandom % N); ny = int'($urandom % N);
      mode = int'($urandom % 5);
      case (mode)
        1: nx = ox;
        2: ny = oy;
        3: begin
          d  = 1 + int'($urandom % (N - 1));
          sx = ($urandom % 2 == 0) ? 1 : -1;
          sy = ($urandom % 2 == 0) ? 1 : -1;
          tx = ox + d * sx; ty = oy + d * sy;
          if (tx >= 0 && tx < N && ty >= 0 && ty < N) begin nx = tx; ny = ty; end
        end
        4: begin
          tx = ox + int'($urandom % 3) - 1;
          ty = oy + int'($urandom % 5) - 2;
          if (tx >= 0 && tx < N && ty >= 0 && ty < N) begin nx = tx; ny = ty; end
        end
        default: ;
      endcase
      run_txn(pc, ox, oy, nx, ny, int'($urandom % 4), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
